// File: rtl/hamming_secded_stream_decoder.sv
// Two-stage extended-Hamming (SECDED) decoder for 8/16/32-bit codewords on a valid/ready stream.
// Saturating error counters are built only when DEC_ERR_COUNTERS_EN is defined.
module hamming_secded_stream_decoder #(
  parameter  int unsigned MAX_WIDTH  = 32,
  parameter  int unsigned CNT_WIDTH  = 16,
  localparam int unsigned DOUT_WIDTH = MAX_WIDTH - $clog2(MAX_WIDTH) - 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [MAX_WIDTH-1:0]  data_in,
  input  logic [1:0]            mode,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DOUT_WIDTH-1:0] data_out,
  output logic [1:0]            status,
  input  logic                  cnt_clr,
  output logic [CNT_WIDTH-1:0]  corr_cnt,
  output logic [CNT_WIDTH-1:0]  uncorr_cnt
);
  localparam int unsigned SYN_W = $clog2(MAX_WIDTH);

  typedef struct packed {
    logic [MAX_WIDTH-1:0] word;
    logic                 illegal;
    logic [SYN_W-1:0]     syn;
    logic                 par;
  } stage1_t;

  // Codeword position carrying payload bit j: ascending positions >= 3 that are not powers of two.
  function automatic int unsigned payload_pos(int unsigned j);
    int unsigned n;
    n = 0;
    payload_pos = 0;
    for (int unsigned i = 3; i < MAX_WIDTH; i++) begin
      if ((i & (i - 1)) != 0) begin
        if (n == j) return i;
        n++;
      end
    end
  endfunction

  logic                 s1_valid;
  stage1_t              s1_q;
  stage1_t              s1_d;
  logic [MAX_WIDTH-1:0] len_mask;
  logic                 in_fire;
  logic                 s2_load;
  logic [MAX_WIDTH-1:0] fixed;
  logic [DOUT_WIDTH-1:0] pay_all;
  logic [1:0]           status_c;

  assign in_ready = !(s1_valid && out_valid && !out_ready);
  assign in_fire  = in_valid && in_ready;
  assign s2_load  = s1_valid && (!out_valid || out_ready);

  // Active-length mask; lengths beyond MAX_WIDTH are illegal.
  always_comb begin
    len_mask  = '0;
    s1_d      = '0;
    s1_d.illegal = 1'b0;
    unique case (mode)
      2'b00: len_mask = MAX_WIDTH'(8'hFF);
      2'b01: begin
        if (MAX_WIDTH >= 16) len_mask = MAX_WIDTH'(16'hFFFF);
        else                 s1_d.illegal = 1'b1;
      end
      2'b10: begin
        if (MAX_WIDTH >= 32) len_mask = '1;
        else                 s1_d.illegal = 1'b1;
      end
      default: s1_d.illegal = 1'b1;
    endcase
    s1_d.word = data_in & len_mask;
    for (int unsigned i = 0; i < MAX_WIDTH; i++) begin
      if (s1_d.word[i]) begin
        s1_d.syn = s1_d.syn ^ SYN_W'(i);
        s1_d.par = ~s1_d.par;
      end
    end
  end

  // Bits above the active length are zero, so the syndrome always lands inside the word.
  always_comb begin
    fixed = s1_q.word;
    if (s1_q.par) fixed[s1_q.syn] = ~s1_q.word[s1_q.syn];
  end

  for (genvar j = 0; j < DOUT_WIDTH; j++) begin : g_pay
    localparam int unsigned POS = payload_pos(j);
    assign pay_all[j] = fixed[POS];
  end

  always_comb begin
    status_c = 2'b00;
    if (s1_q.illegal)          status_c = 2'b11;
    else if (s1_q.par)         status_c = 2'b01;
    else if (s1_q.syn != '0)   status_c = 2'b10;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      s1_valid  <= 1'b0;
      s1_q      <= '0;
      out_valid <= 1'b0;
      data_out  <= '0;
      status    <= 2'b00;
    end else begin
      if (in_fire) begin
        s1_valid <= 1'b1;
        s1_q     <= s1_d;
      end else if (s2_load) begin
        s1_valid <= 1'b0;
      end
      if (s2_load) begin
        out_valid <= 1'b1;
        data_out  <= s1_q.illegal ? '0 : pay_all;
        status    <= status_c;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

`ifdef DEC_ERR_COUNTERS_EN
  logic consume;
  assign consume = out_valid && out_ready;

  // Counts on consumption; clear wins over a coincident increment.
  always_ff @(posedge clk) begin
    if (!rst || cnt_clr) begin
      corr_cnt   <= '0;
      uncorr_cnt <= '0;
    end else if (consume) begin
      if (status == 2'b01 && corr_cnt != '1)   corr_cnt   <= corr_cnt + CNT_WIDTH'(1);
      if (status == 2'b10 && uncorr_cnt != '1) uncorr_cnt <= uncorr_cnt + CNT_WIDTH'(1);
    end
  end
`else
  logic unused_cnt_clr;
  assign unused_cnt_clr = cnt_clr;
  assign corr_cnt       = '0;
  assign uncorr_cnt     = '0;
`endif

endmodule

// File: tb/tb_hamming_secded_stream_decoder.sv
// Directed bench for hamming_secded_stream_decoder: vector table plus reset, backpressure and counter sequences.
module tb_hamming_secded_stream_decoder;
  localparam int unsigned CNT_MAX = 15;
`ifdef DEC_ERR_COUNTERS_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] data_in;
  logic [1:0]  mode;
  logic        out_valid;
  logic        out_ready;
  logic [25:0] data_out;
  logic [1:0]  status;
  logic        cnt_clr;
  logic [3:0]  corr_cnt;
  logic [3:0]  uncorr_cnt;

  hamming_secded_stream_decoder #(.MAX_WIDTH(32), .CNT_WIDTH(4)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .data_in(data_in), .mode(mode), .out_valid(out_valid), .out_ready(out_ready),
    .data_out(data_out), .status(status), .cnt_clr(cnt_clr),
    .corr_cnt(corr_cnt), .uncorr_cnt(uncorr_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] din;
    logic [1:0]  mode;
    logic [25:0] dout;
    logic [1:0]  st;
  } vec_t;

  int n_cmp = 0;
  int n_bad = 0;
  int exp_corr = 0;
  int exp_unc = 0;

  task automatic check(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s[%0d]: got %0h expected %0h", nm, idx, act, exp);
    end
  endtask

  task automatic consume_model(input logic [1:0] st, input bit clr);
    if (!CNT_EN || clr) begin
      exp_corr = 0;
      exp_unc  = 0;
    end else begin
      if (st == 2'b01 && exp_corr != CNT_MAX) exp_corr++;
      if (st == 2'b10 && exp_unc  != CNT_MAX) exp_unc++;
    end
  endtask

  task automatic check_cnts(input string nm, input int idx);
    check({nm, "_corr"}, idx, 32'(corr_cnt), 32'(exp_corr));
    check({nm, "_uncorr"}, idx, 32'(uncorr_cnt), 32'(exp_unc));
  endtask

  // Single word through an idle pipeline with exact latency and consume-time counter checks.
  task automatic run_vec(input string nm, input int idx, input vec_t v);
    @(negedge clk);
    in_valid = 1'b1; data_in = v.din; mode = v.mode; out_ready = 1'b1;
    #1 check({nm, "_in_ready"}, idx, 32'(in_ready), 32'd1);
    @(negedge clk);
    in_valid = 1'b0;
    check({nm, "_lat1"}, idx, 32'(out_valid), 32'd0);
    @(negedge clk);
    check({nm, "_valid"}, idx, 32'(out_valid), 32'd1);
    check({nm, "_data"}, idx, 32'(data_out), 32'(v.dout));
    check({nm, "_status"}, idx, 32'(status), 32'(v.st));
    consume_model(v.st, 1'b0);
    @(negedge clk);
    check({nm, "_drain"}, idx, 32'(out_valid), 32'd0);
    check_cnts(nm, idx);
  endtask

  function automatic logic [31:0] encode32(input logic [25:0] pay);
    logic [31:0] w;
    logic [4:0]  s;
    int k;
    w = '0; s = '0; k = 0;
    for (int i = 3; i < 32; i++) begin
      if ((i & (i - 1)) != 0) begin
        w[i] = pay[k];
        k++;
      end
    end
    for (int i = 1; i < 32; i++) if (w[i]) s = s ^ 5'(i);
    for (int b = 0; b < 5; b++) w[1 << b] = s[b];
    w[0] = ^w;
    return w;
  endfunction

  vec_t vecs[14];
  vec_t sat_v;
  logic [25:0] bp_pay[6];
  int          bp_flip[6];
  logic [31:0] bp_cw[6];
  logic [1:0]  bp_st[6];

  initial begin
    vecs[0]  = '{32'h0000_00AA, 2'b00, 26'hB,       2'b00};
    vecs[1]  = '{32'h0000_008A, 2'b00, 26'hB,       2'b01};
    vecs[2]  = '{32'h0000_00AB, 2'b00, 26'hB,       2'b01};
    vecs[3]  = '{32'h0000_00CA, 2'b00, 26'hD,       2'b10};
    vecs[4]  = '{32'h0000_00AA, 2'b11, 26'h0,       2'b11};
    vecs[5]  = '{32'hFFFF_FF00, 2'b00, 26'h0,       2'b00};
    vecs[6]  = '{32'hFFFF_FFFF, 2'b01, 26'h7FF,     2'b00};
    vecs[7]  = '{32'h0000_2000, 2'b01, 26'h0,       2'b01};
    vecs[8]  = '{32'hFFFF_FFFF, 2'b10, 26'h3FFFFFF, 2'b00};
    vecs[9]  = '{32'h7FFF_FFFF, 2'b10, 26'h3FFFFFF, 2'b01};
    vecs[10] = '{32'hFFFF_FFFE, 2'b10, 26'h3FFFFFF, 2'b01};
    vecs[11] = '{32'h3FFF_FFFF, 2'b10, 26'h0FFFFFF, 2'b10};
    vecs[12] = '{32'h0000_0003, 2'b00, 26'h0,       2'b10};
    vecs[13] = '{32'h0000_00FF, 2'b00, 26'hF,       2'b00};
    sat_v    = '{32'h0000_008A, 2'b00, 26'hB,       2'b01};
    bp_pay   = '{26'h0ABCDEF, 26'h3FFFFFF, 26'h0000001, 26'h2AAAAAA, 26'h1555555, 26'h0F0F0F0};
    bp_flip  = '{-1, 7, 0, -1, 31, 16};
    for (int i = 0; i < 6; i++) begin
      bp_cw[i] = encode32(bp_pay[i]);
      if (bp_flip[i] >= 0) bp_cw[i][bp_flip[i]] = ~bp_cw[i][bp_flip[i]];
      bp_st[i] = (bp_flip[i] >= 0) ? 2'b01 : 2'b00;
    end

    // Reset held with a valid word present.
    rst = 1'b0; in_valid = 1'b1; data_in = 32'hAA; mode = 2'b00; out_ready = 1'b1; cnt_clr = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_out_valid", 0, 32'(out_valid), 32'd0);
    check("rst_data", 0, 32'(data_out), 32'd0);
    check("rst_status", 0, 32'(status), 32'd0);
    check_cnts("rst", 0);
    rst = 1'b1; in_valid = 1'b0;
    @(negedge clk);
    check("rst_in_ready", 0, 32'(in_ready), 32'd1);
    check("rst_idle", 0, 32'(out_valid), 32'd0);

    // A word in flight when reset hits is dropped.
    in_valid = 1'b1; data_in = 32'h8A;
    @(negedge clk);
    in_valid = 1'b0; rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    consume_model(2'b00, 1'b1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("drop_out_valid", i, 32'(out_valid), 32'd0);
    end
    check_cnts("drop", 0);

    for (int i = 0; i < 14; i++) run_vec("vec", i, vecs[i]);

    // Backpressure: stall the consumer for cycles 3-7 of a 6-word stream.
    begin
      int sent = 0;
      int got = 0;
      bit held = 1'b0;
      bit saw_stall = 1'b0;
      logic [25:0] prev_d = '0;
      logic [1:0]  prev_s = '0;
      for (int c = 0; c < 60 && got < 6; c++) begin
        @(negedge clk);
        out_ready = !(c >= 3 && c <= 7);
        in_valid  = (sent < 6);
        data_in   = (sent < 6) ? bp_cw[sent] : 32'h0;
        mode      = 2'b10;
        #1;
        if (held) begin
          check("bp_hold_valid", c, 32'(out_valid), 32'd1);
          check("bp_hold_data", c, 32'(data_out), 32'(prev_d));
          check("bp_hold_status", c, 32'(status), 32'(prev_s));
        end
        if (c == 5) check("bp_in_ready_stalled", c, 32'(in_ready), 32'd0);
        if (!in_ready) saw_stall = 1'b1;
        if (out_valid && out_ready) begin
          check("bp_data", got, 32'(data_out), 32'(bp_pay[got]));
          check("bp_status", got, 32'(status), 32'(bp_st[got]));
          consume_model(bp_st[got], 1'b0);
          got++;
        end
        held   = out_valid && !out_ready;
        prev_d = data_out;
        prev_s = status;
        if (in_valid && in_ready) sent++;
      end
      check("bp_count", 0, 32'(got), 32'd6);
      check("bp_saw_stall", 0, 32'(saw_stall), 32'd1);
      @(negedge clk);
      in_valid = 1'b0;
      check_cnts("bp", 0);
    end

    // Standalone clear, then saturate the correction counter.
    @(negedge clk);
    cnt_clr = 1'b1;
    @(negedge clk);
    cnt_clr = 1'b0;
    consume_model(2'b00, 1'b1);
    check_cnts("clr", 0);
    for (int i = 0; i < 17; i++) run_vec("sat", i, sat_v);
    check("sat_final", 0, 32'(corr_cnt), CNT_EN ? 32'd15 : 32'd0);

    // Clear coincident with an 18th consume.
    @(negedge clk);
    in_valid = 1'b1; data_in = 32'h8A; mode = 2'b00; out_ready = 1'b0;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    check("clr18_valid", 0, 32'(out_valid), 32'd1);
    out_ready = 1'b1; cnt_clr = 1'b1;
    @(negedge clk);
    cnt_clr = 1'b0;
    consume_model(2'b01, 1'b1);
    check("clr18_drain", 0, 32'(out_valid), 32'd0);
    check_cnts("clr18", 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
